// File: rtl/button_gesture_decoder.sv
// Gesture classifier for debounced push-button pulses with a one-deep event register.
// Define GESTURE_REPEAT_EN to emit REPEAT on every hold pulse while held.
module button_gesture_decoder #(
  parameter int LONG_MCEN   = 4,
  parameter int DBL_WIN_CYC = 25000000,
  parameter int WIN_W       = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dpb,
  input  logic       scen,
  input  logic       mcen,
  input  logic       ccen,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf,
  input  logic       ovf_clr
);

  localparam int HW = $clog2(LONG_MCEN + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MCEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DBL_WIN_CYC - 1);

  localparam logic [1:0] EV_SINGLE = 2'd0;
  localparam logic [1:0] EV_DOUBLE = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
`ifdef GESTURE_REPEAT_EN
  localparam logic [1:0] EV_REPEAT = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_WAIT2,
    S_PRESSED2,
    S_HELD
  } state_t;

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [WIN_W-1:0] win_cnt;

  logic       hold_pulse;
  logic       released;
  logic       hold_last;
  logic       emit;
  logic [1:0] emit_code;
  logic       drop;
  logic       unused_ccen;

  // ccen is reserved; the scen-coincident mcen never counts as a hold
  assign unused_ccen = ccen;
  assign hold_pulse  = mcen & ~scen;
  assign released    = ~dpb;
  assign hold_last   = hold_pulse && (hold_cnt == HOLD_LAST);
  assign drop        = emit & evt_valid & ~evt_ready;

  always_comb begin
    emit      = 1'b0;
    emit_code = EV_SINGLE;
    case (state)
      S_PRESSED: begin
        if (!released && hold_last) begin
          emit      = 1'b1;
          emit_code = EV_LONG;
        end
      end
      S_WAIT2: begin
        if (!scen && win_cnt == WIN_LAST) begin
          emit      = 1'b1;
          emit_code = EV_SINGLE;
        end
      end
      S_PRESSED2: begin
        if (released || hold_last) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
        end
      end
`ifdef GESTURE_REPEAT_EN
      S_HELD: begin
        if (!released && hold_pulse) begin
          emit      = 1'b1;
          emit_code = EV_REPEAT;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      win_cnt   <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      evt_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scen) begin
            state    <= S_PRESSED;
            hold_cnt <= '0;
          end
        end
        S_PRESSED, S_PRESSED2: begin
          if (released) begin
            state   <= (state == S_PRESSED) ? S_WAIT2 : S_IDLE;
            win_cnt <= '0;
          end else if (hold_pulse) begin
            hold_cnt <= hold_cnt + HW'(1);
            if (hold_last) state <= S_HELD;
          end
        end
        S_WAIT2: begin
          win_cnt <= win_cnt + WIN_W'(1);
          if (scen) begin
            state    <= S_PRESSED2;
            hold_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            state <= S_IDLE;
          end
        end
        S_HELD: begin
          if (released) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // a stalled consumer keeps the old event; the new one is lost
      if (emit) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= emit_code;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (drop) evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Randomized and directed bench for button_gesture_decoder against a gesture-level model.
// Honors GESTURE_REPEAT_EN the same way as the design.
module tb_button_gesture_decoder;

  localparam int L = 3;
  localparam int W = 8;
`ifdef GESTURE_REPEAT_EN
  localparam int REP_CODE = 3;
  localparam int REP_ON   = 1;
`else
  localparam int REP_CODE = 2;
  localparam int REP_ON   = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       dpb = 1'b0;
  logic       scen = 1'b0;
  logic       mcen = 1'b0;
  logic       ccen = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ovf;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_mode = 0;

  // gesture-level model
  int clicks, holds, gap;
  bit down, long_done;
  bit exp_valid, exp_ovf;
  int exp_code;

  always #5 clk = ~clk;

  button_gesture_decoder #(
    .LONG_MCEN(L),
    .DBL_WIN_CYC(W),
    .WIN_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .dpb(dpb),
    .scen(scen),
    .mcen(mcen),
    .ccen(ccen),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_ready(evt_ready),
    .evt_ovf(evt_ovf),
    .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    clicks = 0; holds = 0; gap = 0;
    down = 0; long_done = 0;
    exp_valid = 0; exp_ovf = 0; exp_code = 0;
  endtask

  task automatic model_step();
    int ev;
    ev = -1;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (clicks == 0) begin
      if (scen) begin
        clicks = 1; down = 1; holds = 0; long_done = 0;
      end
    end else if (down) begin
      if (!dpb) begin
        down = 0;
        if (long_done) clicks = 0;
        else if (clicks == 2) begin ev = 1; clicks = 0; end
        else gap = 0;
      end else if (mcen && !scen) begin
        if (long_done) begin
          if (REP_ON == 1) ev = 3;
        end else begin
          holds++;
          if (holds == L) begin
            long_done = 1;
            ev = (clicks == 2) ? 1 : 2;
          end
        end
      end
    end else begin
      if (scen) begin
        clicks = 2; down = 1; holds = 0; long_done = 0;
      end else if (gap == W - 1) begin
        ev = 0; clicks = 0;
      end else gap++;
    end
    if (ev >= 0) begin
      if (!exp_valid || evt_ready) begin
        exp_valid = 1; exp_code = ev;
      end else exp_ovf = 1;
    end else if (exp_valid && evt_ready) exp_valid = 0;
    if (!(ev >= 0 && exp_valid && !evt_ready) && ovf_clr && !(ev >= 0 && exp_ovf && !evt_ready))
      exp_ovf = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("valid", evt_valid, exp_valid);
    check("code", evt_code, exp_code);
    check("ovf", evt_ovf, exp_ovf);
    if (rand_mode) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic press(input int hold_len, input int n_pulses);
    int p;
    p = 0;
    scen = 1; mcen = 1; dpb = 1;
    step();
    scen = 0; mcen = 0;
    for (int i = 0; i < hold_len; i++) begin
      mcen = (i % 2 == 1) && (p < n_pulses);
      if (mcen) p++;
      step();
    end
    mcen = 0;
  endtask

  task automatic idle(input int n);
    dpb = 0; mcen = 0; scen = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic enter_held();
    scen = 1; mcen = 1; dpb = 1;
    step();
    scen = 0;
    for (int k = 0; k < L; k++) begin
      mcen = 0; step();
      mcen = 1; step();
    end
  endtask

  initial begin
    int n;
    model_reset();
    #1 reset_n = 0;
    #2;
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_ovf", evt_ovf, 0);
    step();
    reset_n = 1;
    evt_ready = 1;
    idle(2);

    // single click and its latency from the release sample
    press(4, 0);
    dpb = 0;
    step();
    n = 1;
    while (!evt_valid && n < 20) begin
      step();
      n++;
    end
    check("single_lat", n, 9);
    check("single_code", evt_code, 0);
    idle(3);

    // double click, second scen four cycles after release
    press(4, 0);
    idle(4);
    press(2, 0);
    dpb = 0;
    step();
    check("double_valid", evt_valid, 1);
    check("double_code", evt_code, 1);
    idle(12);

    // long hold, then back-to-back repeat while the consumer is ready
    enter_held();
    check("long_valid", evt_valid, 1);
    check("long_code", evt_code, 2);
    step();
    check("b2b_valid", evt_valid, REP_ON);
    check("b2b_code", evt_code, REP_CODE);
    check("b2b_ovf", evt_ovf, 0);
    mcen = 0; step();
    mcen = 1; step();
    check("repeat2_code", evt_code, REP_CODE);
    mcen = 0;
    idle(2);
    check("held_release", evt_valid, 0);
    idle(2);

    // backpressure: SINGLE is held, DOUBLE is dropped
    evt_ready = 0;
    press(2, 0);
    idle(10);
    press(2, 0);
    idle(3);
    press(2, 0);
    idle(2);
    check("bp_valid", evt_valid, 1);
    check("bp_code", evt_code, 0);
    check("bp_ovf", evt_ovf, 1);
    ovf_clr = 1; step();
    ovf_clr = 0;
    check("ovf_clr", evt_ovf, 0);
    evt_ready = 1; step();
    check("bp_drain", evt_valid, 0);
    idle(10);

    // asynchronous reset while held
    enter_held();
    reset_n = 0;
    #2;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_code", evt_code, 0);
    check("mid_rst_ovf", evt_ovf, 0);
    step();
    reset_n = 1;
    dpb = 1;
    for (int k = 0; k < 6; k++) begin
      mcen = k[0];
      step();
    end
    mcen = 0;
    check("post_rst_quiet", evt_valid, 0);
    idle(3);

    // randomized gestures with random consumer stalls
    rand_mode = 1;
    for (int g = 0; g < 60; g++) begin
      press($urandom_range(0, 10), $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(0, W));
        press($urandom_range(0, 8), $urandom_range(0, 4));
      end
      idle($urandom_range(0, 12));
    end
    rand_mode = 0;
    evt_ready = 1; ovf_clr = 0;
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_gesture_decoder.md
Name: button_gesture_decoder

Overview:
- Downstream consumer of the push-button debouncer outputs (DPB, SCEN, MCEN, CCEN).
- Classifies each debounced press into one gesture event: SINGLE, DOUBLE, LONG or REPEAT.
- Presents each event to game/control logic through a one-deep valid/ready holding register.
- Sets a sticky overflow flag when an event is dropped because the consumer is stalled.

Parameters:
- LONG_MCEN, 4: number of MCEN pulses after the press-start pulse that qualify a hold as LONG.
- DBL_WIN_CYC, 25000000: clock cycles after a release during which a new SCEN counts as a second click (0.25 s at 100 MHz).
- WIN_W, 25: width of the double-click window counter; must satisfy 2^WIN_W > DBL_WIN_CYC.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dpb  in  1  debounced button level from the debouncer.
- scen  in  1  single-clock enable pulse from the debouncer (press start).
- mcen  in  1  multiple-clock enable pulse from the debouncer (also asserted together with scen).
- ccen  in  1  continuous clock enable from the debouncer; unused, reserved.
- evt_valid  out  1  event available.
- evt_code  out  2  event type: 0 SINGLE, 1 DOUBLE, 2 LONG, 3 REPEAT.
- evt_ready  in  1  consumer accepts the event when evt_valid and evt_ready are both high.
- evt_ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  synchronous clear of evt_ovf.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; hold_cnt = 0; win_cnt = 0.
  - evt_valid = 0, evt_code = 0, evt_ovf = 0.
  - Any pending event is discarded.
- Definitions:
  - "hold pulse" = mcen high with scen low. The mcen that coincides with scen is never counted.
  - "release" = dpb low, sampled as a level.
- hold_cnt is $clog2(LONG_MCEN+1) bits and saturates at LONG_MCEN.
- win_cnt is WIN_W bits.
- State machine:
  - IDLE:
    - scen -> PRESSED, hold_cnt = 0.
  - PRESSED:
    - Release has priority -> WAIT2, win_cnt = 0.
    - Otherwise, on a hold pulse hold_cnt increments.
    - A hold pulse that brings hold_cnt to LONG_MCEN emits LONG -> HELD.
  - WAIT2:
    - win_cnt increments every cycle.
    - scen -> PRESSED2, hold_cnt = 0.
    - Otherwise, when win_cnt == DBL_WIN_CYC-1, emit SINGLE -> IDLE.
    - If scen arrives on the timeout cycle, scen wins: no SINGLE is emitted.
  - PRESSED2:
    - Release emits DOUBLE -> IDLE.
    - A hold pulse bringing hold_cnt to LONG_MCEN emits DOUBLE -> HELD.
  - HELD:
    - Release -> IDLE.
    - Hold pulses emit REPEAT (see Optional Feature).
    - Release has priority over a simultaneous hold pulse.
  - A scen seen in PRESSED, PRESSED2 or HELD is ignored. The debouncer never produces this.
- Emission latency: evt_valid and evt_code are registered and appear in the cycle after the qualifying input is sampled.
- Holding register:
  - Event emitted with evt_valid = 0: load it, set evt_valid = 1.
  - Event emitted with evt_valid = 1 and evt_ready = 1: replace with the new event, keep evt_valid = 1. No gap and no drop.
  - Event emitted with evt_valid = 1 and evt_ready = 0: drop the new event, set evt_ovf = 1, hold the old event unchanged.
  - No event emitted and handshake completes: evt_valid = 0.
  - evt_code holds its last value while evt_valid = 0.
- evt_ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr clears it.
- An asynchronous reset mid-gesture returns to IDLE with no event emitted.

Optional Feature:
- Macro: GESTURE_REPEAT_EN.
- Defined: every hold pulse in HELD emits REPEAT (code 3). This gives auto-repeat at the debouncer MCEN rate.
- Undefined:
  - HELD ignores hold pulses and only waits for release.
  - Code 3 is never produced.
  - No REPEAT logic is synthesized.

Test Plan (LONG_MCEN=3, DBL_WIN_CYC=8):
- Single click: scen+mcen pulse at t0, dpb high for 5 cycles, then low.
  -> Exactly one event, SINGLE (0), with evt_valid rising 9 cycles after release is first sampled.
- Double click: second scen arrives 4 cycles after the first release, then release.
  -> One DOUBLE (1) the cycle after the second release; no SINGLE.
- Long hold with repeat (macro defined): scen+mcen, then 3 isolated mcen pulses.
  -> LONG (2) the cycle after the 3rd pulse.
  -> Next 2 pulses each give REPEAT (3).
  -> Release gives no event.
  - Same stimulus with macro undefined: only LONG.
- Backpressure: evt_ready = 0, produce SINGLE then DOUBLE.
  -> evt_code stays 0, evt_ovf = 1.
  -> ovf_clr pulse -> evt_ovf = 0.
  -> evt_ready = 1 -> evt_valid drops the next cycle.
- Back-to-back accept: evt_valid = 1, evt_ready = 1 in the same cycle a REPEAT is emitted.
  -> evt_valid stays 1, code updates to 3, evt_ovf stays 0.
- Reset mid-hold: assert reset_n low in HELD.
  -> Outputs 0 immediately.
  -> After deassert, mcen pulses with dpb high produce no events until a new scen.
